// File: rtl/nabp_shift_accumulator.sv
// nabp_shift_accumulator
// Per-projection shift scheduler for the NABP shifter. It looks up the step
// base for the projection angle, then runs a DDA-style fractional accumulator
// for a programmed number of steps. Each step hands one shift/no-shift
// decision to the shifter over a valid/ready handshake.
//
// Build option: define NABP_SHIFT_ACCU_ROUND_EN to start the accumulator at
// 0.5, which rounds shift decisions to the nearest pixel centre. With the
// macro undefined the accumulator starts at 0 and decisions truncate.
module nabp_shift_accumulator #(
    parameter int ANGLE_LENGTH   = 9,
    parameter int ACCU_PRECISION = 8,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ANGLE_LENGTH-1:0]   angle,
    input  logic [COUNT_WIDTH-1:0]    num_steps,
    output logic                      busy,
    output logic                      done,
    output logic [ANGLE_LENGTH-1:0]   lut_angle,
    input  logic [ACCU_PRECISION:0]   sh_accu_base,
    output logic                      step_valid,
    input  logic                      step_ready,
    output logic                      shift_en,
    output logic                      sh_axis,
    output logic                      sh_dir
);

    localparam int P = ACCU_PRECISION;

    // The value 1.0 in the widened sum format; any sum at or above it carries.
    localparam logic [P+1:0] ONE = (P+2)'(1) << P;

`ifdef NABP_SHIFT_ACCU_ROUND_EN
    localparam logic [P-1:0] ACCU_INIT = {1'b1, {(P-1){1'b0}}};
`else
    localparam logic [P-1:0] ACCU_INIT = '0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        LATCH,
        RUN,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ANGLE_LENGTH-1:0]  angle_q;
    logic [COUNT_WIDTH-1:0]   cnt_max;
    logic [COUNT_WIDTH-1:0]   cnt;
    logic [P-1:0]             accu;
    logic [P:0]               base_q;
    logic [P+1:0]             sum;
    logic                     last_step;

    // Accumulator plus base, two integer bits wide so the carry is never lost.
    // Both operands are registers, so the step decision cannot depend on
    // step_ready and stays stable across a stall.
    assign sum       = {2'b00, accu} + {1'b0, base_q};
    assign last_step = (cnt == cnt_max - COUNT_WIDTH'(1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        step_valid = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                state_next = LATCH;
            end
            LATCH: begin
                state_next = (cnt_max == '0) ? DONE : RUN;
            end
            RUN: begin
                step_valid = 1'b1;
                shift_en   = (sum >= ONE);
                if (step_ready && last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run parameters, LUT capture and the accumulator/step counter.
    // Everything clears on reset, so a reset mid-run leaves no trace of the
    // aborted projection on lut_angle, sh_axis or sh_dir.
    always_ff @(posedge clk) begin
        if (reset) begin
            angle_q <= '0;
            cnt_max <= '0;
            cnt     <= '0;
            accu    <= '0;
            base_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        angle_q <= angle;
                        cnt_max <= num_steps;
                        accu    <= ACCU_INIT;
                    end
                end
                LATCH: begin
                    base_q <= sh_accu_base;
                    cnt    <= '0;
                end
                RUN: begin
                    if (step_ready) begin
                        accu <= sum[P-1:0];
                        cnt  <= cnt + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The LUT address and the shift geometry both come straight from the
    // captured angle, so they stay fixed for the whole run.
    assign lut_angle = angle_q;
    assign sh_axis   = (angle_q >= ANGLE_LENGTH'(45)) && (angle_q < ANGLE_LENGTH'(135));
    assign sh_dir    = (angle_q >= ANGLE_LENGTH'(90));

endmodule

// File: tb/tb_nabp_shift_accumulator.sv
// Directed testbench for nabp_shift_accumulator with P=8.
// A small registered LUT model returns the programmed base one cycle after
// lut_angle, and per-step expected shift patterns are hand-computed.
module tb_nabp_shift_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] angle;
    logic [7:0] num_steps;
    logic       busy;
    logic       done;
    logic [8:0] lut_angle;
    logic [8:0] sh_accu_base;
    logic       step_valid;
    logic       step_ready;
    logic       shift_en;
    logic       sh_axis;
    logic       sh_dir;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int e0 = 0;

    logic [8:0] lut_mem [0:179];

    nabp_shift_accumulator #(
        .ANGLE_LENGTH(9),
        .ACCU_PRECISION(8),
        .COUNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .angle(angle),
        .num_steps(num_steps),
        .busy(busy),
        .done(done),
        .lut_angle(lut_angle),
        .sh_accu_base(sh_accu_base),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .shift_en(shift_en),
        .sh_axis(sh_axis),
        .sh_dir(sh_dir)
    );

    always #5 clk = ~clk;

    // Registered LUT model; out-of-range addresses return an invalid base.
    always @(posedge clk) begin
        sh_accu_base <= (lut_angle < 9'd180) ? lut_mem[lut_angle] : 9'h1FF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, step_valid, 0);
        check({tag, "_shift"}, shift_en, 0);
    endtask

    // Issue start (edge E0), then walk LOOKUP and LATCH into the first RUN
    // cycle (or DONE when n == 0).
    task automatic start_run(input logic [8:0] a, input logic [7:0] n, input logic [8:0] base,
                             input logic exp_axis, input logic exp_dir);
        lut_mem[a] = base;
        angle      = a;
        num_steps  = n;
        start      = 1'b1;
        tick();
        e0    = edge_cnt;
        start = 1'b0;
        angle = 9'd7;
        num_steps = 8'd99;
        check("lookup_busy", busy, 1);
        check("lookup_lut_angle", lut_angle, a);
        check("lookup_valid", step_valid, 0);
        check("lookup_axis", sh_axis, exp_axis);
        check("lookup_dir", sh_dir, exp_dir);
        tick();
        check("latch_valid", step_valid, 0);
        tick();
    endtask

    // Consume n steps. stall selects ready pattern 1,0,0 repeating; glitch is
    // the step index at which a spurious start is pulsed (-1 for none).
    task automatic do_steps(input int n, input logic [15:0] exp_bits, input logic stall,
                            input int glitch, input logic [8:0] a,
                            input logic exp_axis, input logic exp_dir);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 200) begin
            step_ready = stall ? (cyc % 3 == 0) : 1'b1;
            check("step_valid", step_valid, 1);
            check("step_shift", shift_en, exp_bits[idx]);
            check("step_axis", sh_axis, exp_axis);
            check("step_dir", sh_dir, exp_dir);
            check("step_lut_angle", lut_angle, a);
            check("step_no_done", done, 0);
            if (idx == glitch) begin
                start     = 1'b1;
                angle     = 9'd10;
                num_steps = 8'd1;
            end
            if (step_ready) idx++;
            tick();
            start = 1'b0;
            cyc++;
        end
        check("step_count", idx, n);
        step_ready = 1'b1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", step_valid, 0);
        check("done_axis", sh_axis, exp_axis);
        check("done_dir", sh_dir, exp_dir);
        if (!stall) check("done_latency", edge_cnt - e0, n + 2);
        start = 1'b1;
        angle = 9'd20;
        tick();
        start = 1'b0;
        check_idle("after_done");
        tick();
        check("start_in_done_ignored", busy, 0);
    endtask

    logic [15:0] half_pat;

    initial begin
        for (int i = 0; i < 180; i++) lut_mem[i] = 9'h1FF;
        reset      = 1'b1;
        start      = 1'b0;
        angle      = '0;
        num_steps  = '0;
        step_ready = 1'b1;
`ifdef NABP_SHIFT_ACCU_ROUND_EN
        half_pat = 16'b0101;
`else
        half_pat = 16'b1010;
`endif
        tick();
        tick();
        check_idle("reset");
        check("reset_lut_angle", lut_angle, 0);
        check("reset_axis", sh_axis, 0);
        check("reset_dir", sh_dir, 0);
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Base 0: never shifts.
        start_run(9'd0, 8'd5, 9'h000, 1'b0, 1'b0);
        do_steps(5, 16'b00000, 1'b0, -1, 9'd0, 1'b0, 1'b0);

        // Base 1.0: shifts every step; cot region.
        start_run(9'd45, 8'd4, 9'h100, 1'b1, 1'b0);
        do_steps(4, 16'b1111, 1'b0, -1, 9'd45, 1'b1, 1'b0);

        // Base 0.5: alternating pattern, phase set by the init value.
        start_run(9'd30, 8'd4, 9'h080, 1'b0, 1'b0);
        do_steps(4, half_pat, 1'b0, -1, 9'd30, 1'b0, 1'b0);

        // Same base with stalls: accepted sequence unchanged.
        start_run(9'd120, 8'd4, 9'h080, 1'b1, 1'b1);
        do_steps(4, half_pat, 1'b1, -1, 9'd120, 1'b1, 1'b1);

        // Spurious start during RUN is ignored.
        start_run(9'd150, 8'd4, 9'h080, 1'b0, 1'b1);
        do_steps(4, half_pat, 1'b0, 1, 9'd150, 1'b0, 1'b1);

        // Zero steps: done right after LATCH.
        start_run(9'd90, 8'd0, 9'h100, 1'b1, 1'b1);
        do_steps(0, 16'b0, 1'b0, -1, 9'd90, 1'b1, 1'b1);

        // Reset on the second RUN step.
        start_run(9'd60, 8'd5, 9'h100, 1'b1, 1'b0);
        check("pre_abort_valid", step_valid, 1);
        tick();
        check("abort_step2_valid", step_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        check("abort_lut_angle", lut_angle, 0);
        check("abort_axis", sh_axis, 0);
        check("abort_dir", sh_dir, 0);
        tick();
        check("abort_no_done", done, 0);
        check("abort_still_idle", busy, 0);

        // Fresh run after the abort.
        start_run(9'd0, 8'd3, 9'h080, 1'b0, 1'b0);
        do_steps(3, half_pat, 1'b0, -1, 9'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
